// File: rtl/mem_io_responder_if.sv
// CPU-facing byte-wide memory/IO bus between the CPU top (master) and the memory-side responder (slave).
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128 KB RAM with registered read, plus an IO page at 0x30000
// (UART tx FIFO, one-byte rx buffer, free-running clock counter, program-stop flag).
module mem_io_responder #(
    parameter int unsigned RAM_AW       = 17,
    parameter int unsigned TX_AW        = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                halt,
    output logic                tx_overflow
);
    localparam int unsigned DEPTH = 2 ** TX_AW;
    localparam logic [TX_AW:0] FULL_LVL  = (TX_AW + 1)'(DEPTH);
    localparam logic [TX_AW:0] AFULL_LVL = (TX_AW + 1)'(DEPTH - AFULL_MARGIN);

    logic [7:0] ram  [0:(2 ** RAM_AW) - 1];
    logic [7:0] fifo [0:DEPTH - 1];

    logic [7:0]       mem_din_q, mem_din_d;
    logic [7:0]       rx_q, rx_d;
    logic             rxv_q, rxv_d;
    logic [31:0]      clk_cnt_q, clk_cnt_d;
    logic [23:0]      snap_q, snap_d;
    logic             halt_q, halt_d;
    logic             ovf_q, ovf_d;
    logic [TX_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

    logic              ram_sel, io_sel, io_rd, ram_we;
    logic              tx_wr, halt_wr, push, pop, full, accept;
    logic [2:0]        off;
    logic [7:0]        push_data;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_hi;

    assign unused_hi = ^bus.mem_a[31:18];

    assign ram_sel = ~bus.mem_a[17];
    assign io_sel  = (bus.mem_a[17:16] == 2'b11);
    assign off     = bus.mem_a[2:0];
    assign ram_idx = bus.mem_a[RAM_AW-1:0];
    assign ram_we  = bus.mem_wr & ram_sel;
    assign io_rd   = ~bus.mem_wr & io_sel;

    // A halt write queues a 0x00 marker, deliberately bypassing the zero filter.
    assign tx_wr     = bus.mem_wr & io_sel & (off == 3'd0) & (bus.mem_dout != 8'h00);
    assign halt_wr   = bus.mem_wr & io_sel & (off == 3'd4);
    assign push      = tx_wr | halt_wr;
    assign push_data = halt_wr ? 8'h00 : bus.mem_dout;

    assign tx_valid = (tx_cnt_q != '0);
    assign pop      = tx_valid & tx_ready;
    assign full     = (tx_cnt_q == FULL_LVL);
    assign accept   = push & ~full;

    assign tx_data            = tx_valid ? fifo[rd_ptr_q] : '0;
    assign bus.io_buffer_full = (tx_cnt_q >= AFULL_LVL);
    assign bus.mem_din        = mem_din_q;
    assign halt               = halt_q;
    assign tx_overflow        = ovf_q;

    always_comb begin
        mem_din_d = mem_din_q;
        rx_d      = rx_q;
        rxv_d     = rxv_q;
        snap_d    = snap_q;
        clk_cnt_d = clk_cnt_q;
        halt_d    = halt_q | halt_wr;
        ovf_d     = ovf_q | (push & full);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tx_cnt_d  = tx_cnt_q;

        if (!bus.mem_wr) begin
            if (ram_sel) begin
                mem_din_d = ram[ram_idx];
            end else if (io_sel) begin
                case (off)
                    3'd0:    mem_din_d = rxv_q ? rx_q : 8'h00;
                    3'd4:    mem_din_d = clk_cnt_q[7:0];
                    3'd5:    mem_din_d = snap_q[7:0];
                    3'd6:    mem_din_d = snap_q[15:8];
                    3'd7:    mem_din_d = snap_q[23:16];
                    default: mem_din_d = 8'h00;
                endcase
            end else begin
                mem_din_d = 8'h00;
            end
        end

        if (io_rd && off == 3'd4) snap_d = clk_cnt_q[31:8];

        // The CPU read sees the old byte; a same-cycle strobe still leaves the new byte valid.
        if (io_rd && off == 3'd0) rxv_d = 1'b0;
        if (rx_valid) begin
            rx_d  = rx_data;
            rxv_d = 1'b1;
        end

        if (!halt_q) clk_cnt_d = clk_cnt_q + 32'd1;

        if (accept) wr_ptr_d = wr_ptr_q + TX_AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + TX_AW'(1);
        case ({accept, pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TX_AW + 1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TX_AW + 1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q <= '0;
            rx_q      <= '0;
            rxv_q     <= 1'b0;
            clk_cnt_q <= '0;
            snap_q    <= '0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tx_cnt_q  <= '0;
        end else begin
            mem_din_q <= mem_din_d;
            rx_q      <= rx_d;
            rxv_q     <= rxv_d;
            clk_cnt_q <= clk_cnt_d;
            snap_q    <= snap_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (accept) fifo[wr_ptr_q] <= push_data;
    end
endmodule
